// File: rtl/spi_byte_receiver_if.sv
// Pin-level SPI signals plus the byte-side interface toward the command decoder.
// Master drives the pins and tx_byte; slave is the receiver.
interface spi_byte_receiver_if;
    logic       hw_spi_clk;
    logic       hw_spi_ss;
    logic       hw_spi_mosi;
    logic       hw_spi_miso;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       spi_active;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic [7:0] byte_count;
    logic       frame_abort;

    modport master (
        output hw_spi_clk, hw_spi_ss, hw_spi_mosi, tx_byte,
        input  hw_spi_miso, tx_load, spi_active, byte_out, byte_ready, byte_count, frame_abort
    );

    modport slave (
        input  hw_spi_clk, hw_spi_ss, hw_spi_mosi, tx_byte,
        output hw_spi_miso, tx_load, spi_active, byte_out, byte_ready, byte_count, frame_abort
    );
endinterface

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave byte assembler/transmitter, pins synchronized into clk.
// Latency: pin edge to byte_ready is SYNC_STAGES+2 cycles; no backpressure, bytes are pulsed once.
module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_byte_receiver_if.slave  bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   ss_hist_q;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] byte_out_q;
    logic [7:0] byte_count_q, byte_count_d;
    logic       byte_done_q;
    logic       byte_ready_q;
    logic       frame_abort_q;
    logic       tx_load_q;

    // The ss chain idles high so reset never looks like a frame start by itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.hw_spi_clk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   bus.hw_spi_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.hw_spi_mosi};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s &  sclk_hist_q;
    assign ss_rise   =  ss_s   & ~ss_hist_q;
    assign ss_fall   = ~ss_s   &  ss_hist_q;

    assign bit_cnt_d    = bit_cnt_q + 3'd1;
    assign rx_shift_d   = {rx_shift_q[6:0], mosi_s};
    assign tx_shift_d   = {tx_shift_q[6:0], 1'b0};
    assign byte_count_d = (byte_count_q == 8'hFF) ? 8'hFF : byte_count_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'd0;
            tx_shift_q    <= 8'd0;
            byte_out_q    <= 8'd0;
            byte_count_q  <= 8'd0;
            byte_done_q   <= 1'b0;
            byte_ready_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            tx_load_q     <= 1'b0;
        end else begin
            byte_ready_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            tx_load_q     <= 1'b0;
            byte_done_q   <= 1'b0;

            // Completed byte is published one cycle after its 8th edge.
            if (byte_done_q) begin
                byte_out_q   <= rx_shift_q;
                byte_ready_q <= 1'b1;
                byte_count_q <= byte_count_d;
            end

            if (state_q == IDLE) begin
                if (ss_fall) begin
                    state_q      <= SELECTED;
                    byte_count_q <= 8'd0;
                    tx_shift_q   <= bus.tx_byte;
                    tx_load_q    <= 1'b1;
                    if (sclk_rise) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= 3'd1;
                    end else begin
                        bit_cnt_q  <= 3'd0;
                    end
                end
            end else begin
                if (ss_rise) begin
                    state_q       <= IDLE;
                    bit_cnt_q     <= 3'd0;
                    frame_abort_q <= (bit_cnt_q != 3'd0);
                end else if (sclk_rise) begin
                    rx_shift_q <= rx_shift_d;
                    bit_cnt_q  <= bit_cnt_d;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_q <= 1'b1;
                        tx_shift_q  <= bus.tx_byte;
                        tx_load_q   <= 1'b1;
                    end
                end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                    tx_shift_q <= tx_shift_d;
                end
            end
        end
    end

    assign bus.spi_active  = (state_q == SELECTED);
    assign bus.hw_spi_miso = (state_q == SELECTED) & tx_shift_q[7];
    assign bus.byte_out    = byte_out_q;
    assign bus.byte_ready  = byte_ready_q;
    assign bus.byte_count  = byte_count_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.tx_load     = tx_load_q;

endmodule
